// File: rtl/mem_port_arbiter.sv
// Two-port arbiter that shares one single-port RAM between icache and dcache.
// Ports: clock/reset, icache/dcache cmd+rsp channels, ram_* RAM control, stat_* counters.
module mem_port_arbiter #(
    parameter logic [63:0] PC_START     = 64'h8000_0000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_cmd_valid,
    output logic        icache_cmd_ready,
    input  logic [63:0] icache_cmd_addr,
    output logic        icache_rsp_valid,
    output logic [31:0] icache_rsp_data,
    input  logic        dcache_cmd_valid,
    output logic        dcache_cmd_ready,
    input  logic [63:0] dcache_cmd_addr,
    input  logic        dcache_cmd_wen,
    input  logic [63:0] dcache_cmd_wdata,
    input  logic [7:0]  dcache_cmd_wstrb,
    output logic        dcache_rsp_valid,
    output logic [63:0] dcache_rsp_data,
    output logic        ram_en,
    output logic [27:0] ram_idx,
    output logic        ram_wen,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    input  logic [63:0] ram_rdata,
    output logic [31:0] stat_igrant,
    output logic [31:0] stat_dgrant,
    output logic [31:0] stat_conflict
);

    typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} rsp_state_t;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    rsp_state_t state, state_next;
    logic [3:0]  starve_cnt;
    logic        conflict;
    logic        i_win;
    logic        i_grant;
    logic        d_grant;
    logic [63:0] i_off;
    logic [63:0] d_off;
    logic [63:0] sel_off;

    assign i_off    = icache_cmd_addr - PC_START;
    assign d_off    = dcache_cmd_addr - PC_START;
    assign conflict = !reset && icache_cmd_valid && dcache_cmd_valid;

    // icache wins when alone, or when it has been starved long enough
    assign i_win   = icache_cmd_valid && (!dcache_cmd_valid || starve_cnt == LIMIT);
    assign i_grant = !reset && i_win;
    assign d_grant = !reset && dcache_cmd_valid && !i_win;

    assign icache_cmd_ready = i_grant;
    assign dcache_cmd_ready = d_grant;

    assign sel_off = i_grant ? i_off : d_off;
    assign ram_idx = sel_off[30:3];
    assign ram_en  = i_grant || d_grant;
    assign ram_wen = d_grant && dcache_cmd_wen;

    always_comb begin
        ram_wdata = 64'd0;
        ram_wmask = 64'd0;
        if (ram_wen) begin
            ram_wdata = dcache_cmd_wdata;
            for (int b = 0; b < 8; b++) begin
                ram_wmask[b*8 +: 8] = {8{dcache_cmd_wstrb[b]}};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // State records what the previous cycle granted; reset masks a pending pulse
    always_comb begin
        state_next       = IDLE;
        icache_rsp_valid = 1'b0;
        dcache_rsp_valid = 1'b0;
        if (i_grant) begin
            state_next = I_RD;
        end else if (d_grant) begin
            state_next = dcache_cmd_wen ? D_WR : D_RD;
        end
        if (!reset) begin
            icache_rsp_valid = (state == I_RD);
            dcache_rsp_valid = (state == D_RD);
        end
    end

    // Read data is captured at the grant edge, ahead of any write on the next edge
    always_ff @(posedge clock) begin
        if (reset) begin
            icache_rsp_data <= 32'd0;
            dcache_rsp_data <= 64'd0;
        end else begin
            if (i_grant) begin
                icache_rsp_data <= i_off[2] ? ram_rdata[63:32] : ram_rdata[31:0];
            end
            if (d_grant && !dcache_cmd_wen) begin
                dcache_rsp_data <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (i_grant) begin
            starve_cnt <= 4'd0;
        end else if (conflict && starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_igrant   <= 32'd0;
            stat_dgrant   <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (i_grant)  stat_igrant   <= stat_igrant + 32'd1;
            if (d_grant)  stat_dgrant   <= stat_dgrant + 32'd1;
            if (conflict) stat_conflict <= stat_conflict + 32'd1;
        end
    end

endmodule
